// File: rtl/fft_pkg.sv
// Shared definitions for the FFT transmit framer: state encoding, defaults and widths.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CFG  = 2'd1,
    ST_FILL = 2'd2,
    ST_SEND = 2'd3
  } fft_tx_state_t;

  localparam int          FFT_LEN_DEF = 1024;
  localparam logic [15:0] FFT_CFG_FWD = 16'h0001;
  localparam int          FFT_TDATA_W = 32;

endpackage

// File: rtl/fft_tx_ram.sv
// Single-port sample buffer with a registered read; one access per cycle, write or read.
module fft_tx_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem_q [DEPTH];
  logic [15:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fft_frame_tx.sv
// Frame collector and AXI4-Stream sender for the FFT core input.
// Define FFT_FRAME_TX_CONFIG_EN to issue the one-time config word after reset.
module fft_frame_tx
  import fft_pkg::*;
#(
  parameter int          FFT_LEN  = FFT_LEN_DEF,
  parameter int          DATA_W   = 16,
  parameter logic [15:0] CFG_WORD = FFT_CFG_FWD
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [15:0]            m_axis_config_tdata,
  output logic                   m_axis_config_tvalid,
  input  logic                   m_axis_config_tready,
  output logic [FFT_TDATA_W-1:0] m_axis_data_tdata,
  output logic                   m_axis_data_tvalid,
  input  logic                   m_axis_data_tready,
  output logic                   m_axis_data_tlast,
  output logic [15:0]            frame_cnt,
  output logic                   busy
);

  localparam int          AW       = $clog2(FFT_LEN);
  localparam logic [AW-1:0] LAST_ADDR = AW'(FFT_LEN - 1);
  localparam logic [1:0]  S_IDLE   = ST_IDLE;
  localparam logic [1:0]  S_CFG    = ST_CFG;
  localparam logic [1:0]  S_FILL   = ST_FILL;
  localparam logic [1:0]  S_SEND   = ST_SEND;

  function automatic logic [15:0] sext16(input logic [DATA_W-1:0] x);
    return 16'($signed(x));
  endfunction

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          rd_done_q, rd_done_d;
  logic          rd_vld_q, rd_vld_d;
  logic          rd_last_q, rd_last_d;
  logic          out_vld_q, out_vld_d;
  logic [15:0]   out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic          skid_vld_q, skid_vld_d;
  logic [15:0]   skid_data_q, skid_data_d;
  logic          skid_last_q, skid_last_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_rdata;
  logic          pop;
  logic          rd_issue;
  logic [1:0]    occ;

  fft_tx_ram #(.DEPTH(FFT_LEN), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (sext16(in_data)),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_done_d   = rd_done_q;
    rd_vld_d    = 1'b0;
    rd_last_d   = 1'b0;
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    frame_cnt_d = frame_cnt_q;
    ram_we      = 1'b0;
    ram_addr    = rd_ptr_q;
    rd_issue    = 1'b0;
    pop         = out_vld_q && m_axis_data_tready;
    // Beats held or in flight: output reg + skid + pending RAM read never exceed two.
    occ         = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, rd_vld_q};

    case (state_q)
      S_IDLE: begin
`ifdef FFT_FRAME_TX_CONFIG_EN
        state_d = S_CFG;
`else
        state_d = S_FILL;
`endif
      end
      S_FILL: begin
        ram_addr = wr_ptr_q;
        if (in_valid) begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == LAST_ADDR) state_d = S_SEND;
        end
      end
      S_SEND: begin
        rd_issue = !rd_done_q && ((occ < 2'd2) || pop);
        if (pop && out_last_q) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          rd_done_d   = 1'b0;
          state_d     = S_FILL;
        end
      end
      default: begin
`ifdef FFT_FRAME_TX_CONFIG_EN
        if (m_axis_config_tready) state_d = S_FILL;
`else
        state_d = S_IDLE;
`endif
      end
    endcase

    if (rd_issue) begin
      rd_vld_d  = 1'b1;
      rd_last_d = (rd_ptr_q == LAST_ADDR);
      rd_ptr_d  = rd_ptr_q + 1'b1;
      if (rd_ptr_q == LAST_ADDR) rd_done_d = 1'b1;
    end

    // Output register refills from the skid first so beat order is preserved.
    if (!out_vld_q || pop) begin
      if (skid_vld_q) begin
        out_vld_d   = 1'b1;
        out_data_d  = skid_data_q;
        out_last_d  = skid_last_q;
        skid_vld_d  = rd_vld_q;
        skid_data_d = ram_rdata;
        skid_last_d = rd_last_q;
      end else if (rd_vld_q) begin
        out_vld_d  = 1'b1;
        out_data_d = ram_rdata;
        out_last_d = rd_last_q;
      end else begin
        out_vld_d  = 1'b0;
        out_last_d = 1'b0;
      end
    end else if (rd_vld_q) begin
      skid_vld_d  = 1'b1;
      skid_data_d = ram_rdata;
      skid_last_d = rd_last_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_done_q   <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_done_q   <= rd_done_d;
      rd_vld_q    <= rd_vld_d;
      rd_last_q   <= rd_last_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign in_ready           = (state_q == S_FILL);
  assign busy               = (state_q == S_CFG) || (state_q == S_SEND);
  assign m_axis_data_tvalid = out_vld_q;
  assign m_axis_data_tdata  = {16'h0000, out_data_q};
  assign m_axis_data_tlast  = out_last_q;
  assign frame_cnt          = frame_cnt_q;

`ifdef FFT_FRAME_TX_CONFIG_EN
  assign m_axis_config_tvalid = (state_q == S_CFG);
  assign m_axis_config_tdata  = (state_q == S_CFG) ? CFG_WORD : 16'h0000;
`else
  logic unused_cfg;
  assign unused_cfg           = ^{m_axis_config_tready, CFG_WORD};
  assign m_axis_config_tvalid = 1'b0;
  assign m_axis_config_tdata  = 16'h0000;
`endif

endmodule

// File: tb/tb_fft_frame_tx.sv
// Scoreboard bench for fft_frame_tx: driver feeds frames and queues expected beats, monitor pops on handshakes.
module tb_fft_frame_tx;

  localparam int FFT_LEN = 1024;
  localparam int DATA_W  = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       cfg_tdata;
  logic              cfg_tvalid;
  logic              cfg_tready;
  logic [31:0]       tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [15:0]       frame_cnt;
  logic              busy;

  fft_frame_tx #(.FFT_LEN(FFT_LEN), .DATA_W(DATA_W), .CFG_WORD(16'h0001)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .in_data              (in_data),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .m_axis_config_tdata  (cfg_tdata),
    .m_axis_config_tvalid (cfg_tvalid),
    .m_axis_config_tready (cfg_tready),
    .m_axis_data_tdata    (tdata),
    .m_axis_data_tvalid   (tvalid),
    .m_axis_data_tready   (tready),
    .m_axis_data_tlast    (tlast),
    .frame_cnt            (frame_cnt),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          tready_mode = 0;
  int          beat_cnt = 0;
  int          first_cyc = 0;
  int          last_acc = 0;
  int          fc_exp = 0;
  bit          fc_pending = 0;
  bit          phase_fill = 0;
  logic [32:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sample to beat: two's-complement DATA_W value widened to 16 bits, imag half zero.
  function automatic logic [31:0] pack(input int s);
    int v;
    v = (s >= (1 << (DATA_W - 1))) ? s - (1 << DATA_W) : s;
    return 32'(v & 32'h0000_FFFF);
  endfunction

  task automatic check_reset_vals();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_cfg_tvalid", 32'(cfg_tvalid), 0);
    chk("rst_cfg_tdata", 32'(cfg_tdata), 0);
    chk("rst_tvalid", 32'(tvalid), 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tlast", 32'(tlast), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
  endtask

  task automatic startup();
    int hs;
    cfg_tready = 1'b0;
    @(negedge clk); #1;
`ifdef FFT_FRAME_TX_CONFIG_EN
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      chk("cfg_tvalid_stall", 32'(cfg_tvalid), 1);
      chk("cfg_tdata_stall", 32'(cfg_tdata), 32'h0001);
      chk("cfg_in_ready_low", 32'(in_ready), 0);
      chk("cfg_busy", 32'(busy), 1);
    end
    hs = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cfg_tready = 1'b1;
      #1;
      if (cfg_tvalid && cfg_tready) hs++;
    end
    chk("cfg_handshakes", 32'(hs), 1);
    chk("cfg_then_fill", 32'(in_ready), 1);
`else
    hs = 0;
    chk("nocfg_tvalid", 32'(cfg_tvalid), 0);
    chk("nocfg_tdata", 32'(cfg_tdata), 0);
    chk("nocfg_fill", 32'(in_ready), 1);
    chk("nocfg_busy", 32'(busy + hs), 0);
`endif
    phase_fill = 1'b1;
  endtask

  // kind 0: ramp, always valid; 1: ramp, random valid; 2: random data, random valid.
  task automatic fill_frame(input int kind);
    int k = 0;
    int guard = 0;
    int s;
    int frame [FFT_LEN];
    while (k < FFT_LEN && guard < 8 * FFT_LEN) begin
      @(negedge clk);
      guard++;
      in_valid = (kind == 0) ? 1'b1 : (($urandom % 4) != 0);
      if (kind == 2) s = (k == 0) ? 'h800 : (k == 1) ? 'h7FF : int'($urandom % 4096);
      else s = k;
      in_data = DATA_W'(s);
      #1;
      chk("in_ready_fill", 32'(in_ready), 1);
      chk("busy_fill", 32'(busy), 0);
      if (in_valid) begin
        frame[k] = s;
        k++;
        if (k == FFT_LEN) begin
          last_acc = cyc + 1;
          for (int j = 0; j < FFT_LEN; j++) exp_q.push_back({(j == FFT_LEN - 1), pack(frame[j])});
          phase_fill = 1'b0;
        end
      end
    end
    if (k < FFT_LEN) begin
      n_vec++; n_err++;
      $display("FAIL fill_timeout: got %0d samples required %0d", k, FFT_LEN);
    end
  endtask

  task automatic wait_send(input int rst_at);
    int  n = 0;
    bit  done = 0;
    while (!done) begin
      @(negedge clk);
      if (phase_fill) begin
        in_valid = 1'b0;
        #1;
        chk("fill_reentry_ready", 32'(in_ready), 1);
        done = 1;
      end else if (rst_at >= 0 && beat_cnt >= rst_at) begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        fc_exp = 0;
        fc_pending = 0;
        beat_cnt = 0;
        #1;
        check_reset_vals();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        startup();
        done = 1;
      end else begin
        in_valid = 1'b1;
        in_data  = DATA_W'(16'hDEAD);
        #1;
        chk("in_ready_send", 32'(in_ready), 0);
        chk("busy_send", 32'(busy), 1);
        n++;
        if (n > 8 * FFT_LEN) begin
          n_vec++; n_err++;
          $display("FAIL send_timeout: got %0d beats required %0d", beat_cnt, FFT_LEN);
          done = 1;
        end
      end
    end
  endtask

  bit          have_prev = 0;
  logic        prev_v, prev_r, prev_l;
  logic [31:0] prev_d;
  logic [32:0] e;

  always begin
    @(negedge clk);
    case (tready_mode)
      0: tready = 1'b1;
      1: tready = (cyc % 2) == 0;
      default: tready = ($urandom % 3) != 0;
    endcase
    #2;
    cyc++;
    if (!rst_n) begin
      have_prev = 0;
    end else begin
      if (fc_pending) begin
        chk("frame_cnt", 32'(frame_cnt), 32'(fc_exp));
        fc_pending = 0;
      end
      if (have_prev && prev_v && !prev_r) begin
        chk("hold_tvalid", 32'(tvalid), 1);
        chk("hold_tdata", tdata, prev_d);
        chk("hold_tlast", 32'(tlast), 32'(prev_l));
      end
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL spurious_beat: got %h with no beat expected", tdata);
        end else begin
          e = exp_q.pop_front();
          chk("beat_tdata", tdata, e[31:0]);
          chk("beat_tlast", 32'(tlast), 32'(e[32]));
          if (beat_cnt == 0) begin
            first_cyc = cyc;
            if (tready_mode == 0) chk("first_beat_latency", 32'((cyc - last_acc) <= 3), 1);
          end
          beat_cnt++;
          if (e[32]) begin
            if (tready_mode == 0) chk("burst_no_bubbles", 32'(cyc - first_cyc), 32'(FFT_LEN - 1));
            fc_exp = (fc_exp + 1) & 16'hFFFF;
            fc_pending = 1;
            beat_cnt = 0;
            phase_fill = 1'b1;
          end
        end
      end
      have_prev = 1;
      prev_v = tvalid;
      prev_r = tready;
      prev_d = tdata;
      prev_l = tlast;
    end
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    cfg_tready = 1'b0;
    tready_mode = 0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    startup();

    tready_mode = 0; fill_frame(0); wait_send(-1);
    tready_mode = 1; fill_frame(1); wait_send(-1);
    tready_mode = 2; fill_frame(2); wait_send(-1);
    tready_mode = 0; fill_frame(0); wait_send(500);
    tready_mode = 2; fill_frame(2); wait_send(-1);
    tready_mode = 0; fill_frame(1); wait_send(-1);

    repeat (4) @(negedge clk);
    chk("final_frame_cnt", 32'(frame_cnt), 2);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft_frame_tx.md
# fft_frame_tx

Transmit-side framer for the FFT core's sample input. It collects one frame of real-valued samples from an upstream source into a local buffer. It then streams that frame into the FFT core's AXI4-Stream slave data port as packed complex words, with `tlast` on the final beat. When enabled, it also issues the one-time configuration word on the core's config channel after reset. It sits between the ADC/sample generator and `FFT_Control`-style core wrappers.

## Interface
Parameters:
- `FFT_LEN`, 1024, samples per frame; power of two, 16..65536
- `DATA_W`, 16, input sample width, 8..16, two's complement
- `CFG_WORD`, 16'h0001, config word; bit0 = 1 selects forward transform

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_data`  in  DATA_W  upstream sample
- `in_valid`  in  1  `in_data` is valid this cycle
- `in_ready`  out  1  block accepts a sample this cycle
- `m_axis_config_tdata`  out  16  config word
- `m_axis_config_tvalid`  out  1  config word valid
- `m_axis_config_tready`  in  1  core accepts the config word
- `m_axis_data_tdata`  out  32  {imag[15:0]=0, real[15:0]}
- `m_axis_data_tvalid`  out  1  beat valid
- `m_axis_data_tready`  in  1  core accepts the beat
- `m_axis_data_tlast`  out  1  last beat of the frame
- `frame_cnt`  out  16  count of completed frames; wraps at 16'hFFFF to 0
- `busy`  out  1  high in CFG and SEND

## Operation
- States: IDLE, CFG, FILL, SEND.
- IDLE lasts one cycle after reset deassertion. It then goes to CFG if config is compiled in, otherwise to FILL.
- CFG:
  - `m_axis_config_tvalid`=1 and `m_axis_config_tdata`=CFG_WORD.
  - Move to FILL on the cycle where tvalid and tready are both high.
  - CFG is entered only once per reset.
- FILL:
  - `in_ready`=1.
  - Each `in_valid` cycle writes `in_data` to buffer address `wr_ptr`, then increments `wr_ptr`.
  - When the write at address FFT_LEN-1 occurs, `wr_ptr` wraps to 0, the next state is SEND, and `in_ready` drops on the following cycle.
- SEND:
  - `in_ready`=0; `in_valid` is ignored and samples offered then are dropped by contract.
  - Beats are read in address order 0..FFT_LEN-1.
  - `tlast`=1 only on beat FFT_LEN-1.
  - On the handshake of the `tlast` beat: `frame_cnt` increments, then go to FILL.
- Packing:
  - `tdata[15:0]` = `in_data` sign-extended to 16 bits.
  - `tdata[31:16]` = 0.
- AXI rules:
  - Once `tvalid` is asserted, `tdata`, `tlast` and `tvalid` hold until the handshake.
  - `tvalid` does not depend on `tready`.
- Reset mid-operation: any state returns to IDLE and pointers clear. In-flight frame contents are discarded. Config is re-issued.

## Timing
- Reset values:
  - `in_ready`=0, `m_axis_config_tvalid`=0, `m_axis_config_tdata`=0.
  - `m_axis_data_tvalid`=0, `m_axis_data_tdata`=0, `m_axis_data_tlast`=0.
  - `frame_cnt`=0, `busy`=0.
- Buffer RAM has a 1-cycle registered read.
- First `tvalid` is asserted no later than 2 cycles after entering SEND.
- With `tready` held high, one beat per cycle and no bubbles: FFT_LEN beats in FFT_LEN consecutive cycles.
- Under backpressure, read prefetch stalls via a one-entry skid register. No beat is lost or duplicated.
- FILL is entered on the cycle after the `tlast` handshake. `in_ready` rises in that same cycle.

## Configuration
- Macro: `FFT_FRAME_TX_CONFIG_EN`.
- Defined: the CFG state exists and the config channel behaves as above.
- Undefined:
  - CFG is removed and IDLE goes directly to FILL.
  - `m_axis_config_tvalid` and `m_axis_config_tdata` are tied to 0.
  - `m_axis_config_tready` is ignored.

## Structure
- Shared package `fft_pkg`:
  - state enum `fft_tx_state_t`
  - `FFT_LEN_DEF`
  - `FFT_CFG_FWD` (16'h0001)
  - `FFT_TDATA_W` (32)
- Sub-module `fft_tx_ram`:
  - single-port FFT_LEN x 16 RAM with registered read
  - single-port is enough because writes (FILL) and reads (SEND) never overlap

## Test plan
- Ramp 0..1023 in FILL, `tready`=1 → 1024 consecutive beats with `tdata`=k for k=0..1023. `tlast` only on k=1023. `frame_cnt`=1 afterwards.
- Same ramp, `tready` alternating 1/0 each cycle → each beat's data held stable while stalled. Received sequence exactly 0..1023. Last beat's handshake has `tlast`=1.
- `m_axis_config_tready`=0 for 5 cycles after reset → config `tvalid`=1 with `tdata`=16'h0001 throughout, `in_ready`=0. Exactly one config handshake, then `in_ready`=1.
- `DATA_W`=12, sample 12'h800 → `tdata`=32'h0000F800. Sample 12'h7FF → `tdata`=32'h000007FF.
- Assert `rst_n`=0 at beat 500 of SEND → next cycle all outputs at reset values. After release, config re-issued and FILL starts at address 0.
- `in_valid`=1 throughout SEND with value 16'hDEAD → no write occurs. The next frame contains only samples accepted during its own FILL.
